dp_sort_engine: RTL

//  Compare-and-swap bubble-sort engine; direct consumer of dp_sub (its difference/borrow drives the swap decision).

---
 rtl/dp_sort_engine_pkg.sv | 14 +
 rtl/dp_sort_engine_if.sv | 26 ++
 rtl/dp_sub.sv | 10 +
 rtl/dp_sort_engine.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dp_sort_engine_pkg.sv
// Shared types and defaults for the compare-and-swap sort engine.
package dp_sort_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SORT,
        S_UNLOAD
    } sort_state_e;

    localparam int DW_DEF   = 8;
    localparam int NUM_DEF  = 8;
    localparam int IDXW_DEF = 3;

endpackage

// File: rtl/dp_sort_engine_if.sv
// Load / control / unload handshake bundle of the sort engine.
interface dp_sort_engine_if
    import dp_sort_engine_pkg::*;
#(
    parameter int datawidth = DW_DEF
);
    logic                 In_Valid;
    logic [datawidth-1:0] In_Data;
    logic                 In_Ready;
    logic                 Go;
    logic                 Busy;
    logic                 Out_Valid;
    logic                 Out_Ready;
    logic [datawidth-1:0] Out_Data;
    logic                 Done;

    modport master (
        output In_Valid, In_Data, Go, Out_Ready,
        input  In_Ready, Busy, Out_Valid, Out_Data, Done
    );

    modport slave (
        input  In_Valid, In_Data, Go, Out_Ready,
        output In_Ready, Busy, Out_Valid, Out_Data, Done
    );
endinterface

// File: rtl/dp_sub.sv
// Plain unsigned subtractor; callers widen operands by one bit to get a borrow MSB.
module dp_sub #(
    parameter int datawidth = 9
) (
    input  logic [datawidth-1:0] a,
    input  logic [datawidth-1:0] b,
    output logic [datawidth-1:0] diff
);
    assign diff = a - b;
endmodule

// File: rtl/dp_sort_engine.sv
// Serial-load bubble sorter: one compare-and-swap per clock, streams words out smallest first.
module dp_sort_engine
    import dp_sort_engine_pkg::*;
#(
    parameter int datawidth = DW_DEF,
    parameter int NUM       = NUM_DEF,
    parameter int IDXW      = IDXW_DEF
) (
    input logic              Clk,
    input logic              Rst,
    dp_sort_engine_if.slave  bus
);
    localparam logic [IDXW:0]   CNT_FULL = (IDXW + 1)'(NUM);
    localparam logic [IDXW-1:0] J_BASE   = IDXW'(NUM - 2);
    localparam logic [IDXW-1:0] RP_LAST  = IDXW'(NUM - 1);

    sort_state_e state_q, state_d;
    logic [IDXW:0]        count_q, count_d;
    logic [IDXW-1:0]      j_q, j_d;
    logic [IDXW-1:0]      pass_q, pass_d;
    logic [IDXW-1:0]      rp_q, rp_d;
    logic                 swapped_q, swapped_d;
    logic                 done_q, done_d;
    logic [datawidth-1:0] arr_q [NUM];
    logic [datawidth-1:0] arr_d [NUM];

    logic [IDXW-1:0]      j_nx;
    logic [datawidth:0]   cmp_diff;
    logic                 swap;
    logic                 in_ready;
    logic                 out_valid;

    assign j_nx = j_q + 1'b1;

    // Zero-extended subtract: MSB is the borrow, so no sign confusion on 8-bit data.
    dp_sub #(
        .datawidth (datawidth + 1)
    ) u_cmp (
        .a    ({1'b0, arr_q[j_q]}),
        .b    ({1'b0, arr_q[j_nx]}),
        .diff (cmp_diff)
    );

    assign swap      = ~cmp_diff[datawidth] && (cmp_diff != '0);
    assign in_ready  = (state_q == S_IDLE) && (count_q < CNT_FULL);
    assign out_valid = (state_q == S_UNLOAD);

    assign bus.In_Ready  = in_ready;
    assign bus.Busy      = (state_q == S_SORT) || (state_q == S_UNLOAD);
    assign bus.Out_Valid = out_valid;
    assign bus.Out_Data  = out_valid ? arr_q[rp_q] : '0;
    assign bus.Done      = done_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        j_d       = j_q;
        pass_d    = pass_q;
        rp_d      = rp_q;
        swapped_d = swapped_q;
        done_d    = 1'b0;
        arr_d     = arr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.In_Valid && in_ready) begin
                    arr_d[count_q[IDXW-1:0]] = bus.In_Data;
                    count_d = count_q + 1'b1;
                end
                if (bus.Go && count_q == CNT_FULL) begin
                    state_d   = S_SORT;
                    j_d       = '0;
                    pass_d    = '0;
                    swapped_d = 1'b0;
                end
            end
            S_SORT: begin
                if (swap) begin
                    arr_d[j_q]  = arr_q[j_nx];
                    arr_d[j_nx] = arr_q[j_q];
                    swapped_d   = 1'b1;
                end
                // Each pass parks the largest remaining word, so the span shrinks by one.
                if (j_q == J_BASE - pass_q) begin
                    if (!(swapped_q || swap) || pass_q == J_BASE) begin
                        state_d = S_UNLOAD;
                        rp_d    = '0;
                    end else begin
                        pass_d    = pass_q + 1'b1;
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d = j_nx;
                end
            end
            S_UNLOAD: begin
                if (bus.Out_Ready) begin
                    if (rp_q == RP_LAST) begin
                        state_d = S_IDLE;
                        count_d = '0;
                        rp_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        rp_d = rp_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            j_q       <= '0;
            pass_q    <= '0;
            rp_q      <= '0;
            swapped_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM; i++) arr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            rp_q      <= rp_d;
            swapped_q <= swapped_d;
            done_q    <= done_d;
            for (int i = 0; i < NUM; i++) arr_q[i] <= arr_d[i];
        end
    end
endmodule
